// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - parametrised oversampling UART receive engine with voting, parity, break and overrun
module uart_rx_engine #(
  parameter int MAX_DATA_W     = 9,
  parameter int OVERSAMPLE     = 16,
  parameter int SAMPLE_COUNT_W = $clog2(OVERSAMPLE),
  parameter int DATA_LEN_W     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  baud_en_i,
  input  logic                  rx_en_i,
  input  logic                  uart_rx_i,
  input  logic [DATA_LEN_W-1:0] data_bits_i,
  input  logic [1:0]            parity_mode_i,
  input  logic                  stop2_i,
  input  logic                  rx_ready_i,
  output logic                  rx_valid_o,
  output logic [MAX_DATA_W-1:0] rx_data_o,
  output logic                  rx_parity_err_o,
  output logic                  rx_frame_err_o,
  output logic                  rx_break_o,
  output logic                  rx_noise_o,
  output logic                  rx_overrun_o,
  output logic                  rx_busy_o
);

  localparam logic [SAMPLE_COUNT_W-1:0] CNT_PRE  = SAMPLE_COUNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMPLE_COUNT_W-1:0] CNT_MID  = SAMPLE_COUNT_W'(OVERSAMPLE / 2);
  localparam logic [SAMPLE_COUNT_W-1:0] CNT_POST = SAMPLE_COUNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SAMPLE_COUNT_W-1:0] CNT_LAST = SAMPLE_COUNT_W'(OVERSAMPLE - 1);
  localparam logic [DATA_LEN_W-1:0]     BITS_MIN = DATA_LEN_W'(5);
  localparam logic [DATA_LEN_W-1:0]     BITS_MAX = DATA_LEN_W'(MAX_DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                  state_q;
  logic [SAMPLE_COUNT_W-1:0] cnt_q;
  logic [DATA_LEN_W-1:0]   bit_idx_q;
  logic [DATA_LEN_W-1:0]   n_bits_q;
  logic [1:0]              par_mode_q;
  logic                    stop2_q;
  logic                    stop_idx_q;
  logic                    s_pre_q;
  logic                    s_mid_q;
  logic [MAX_DATA_W-1:0]   data_q;
  logic                    par_bit_q;
  logic                    noise_q;
  logic                    frame_q;
  logic                    first_stop_q;
  logic                    busy_q;
  logic                    done_q;
  logic [MAX_DATA_W-1:0]   res_data_q;
  logic                    res_par_err_q;
  logic                    res_frame_q;
  logic                    res_break_q;
  logic                    res_noise_q;

  logic [DATA_LEN_W-1:0]   cfg_bits;
  logic                    vote;
  logic                    split;
  logic                    at_vote;
  logic                    at_last;
  logic                    final_stop;
  logic                    fin_first_stop;
  logic                    fin_break;
  logic                    par_xor;
  logic                    par_err;

  // Clamp the requested character length into the supported 5..MAX_DATA_W range
  always_comb begin
    cfg_bits = data_bits_i;
    if (data_bits_i < BITS_MIN) begin
      cfg_bits = BITS_MIN;
    end else if (data_bits_i > BITS_MAX) begin
      cfg_bits = BITS_MAX;
    end
  end

  // Majority of the two stored samples and the live third sample taken at M+1
  assign vote       = (s_pre_q & s_mid_q) | (s_pre_q & uart_rx_i) | (s_mid_q & uart_rx_i);
  assign split      = (s_pre_q != s_mid_q) | (s_mid_q != uart_rx_i);
  assign at_vote    = (cnt_q == CNT_POST);
  assign at_last    = (cnt_q == CNT_LAST);
  assign final_stop = ~stop2_q | stop_idx_q;

  // Character verdict evaluated on the final stop vote; break needs every received bit low
  assign fin_first_stop = stop_idx_q ? first_stop_q : vote;
  assign fin_break      = (data_q == '0) & ((par_mode_q == 2'b00) | ~par_bit_q) & ~fin_first_stop;
  assign par_xor        = (^data_q) ^ par_bit_q;

  // Parity check selected by the latched parity mode
  always_comb begin
    par_err = 1'b0;
    case (par_mode_q)
      2'b01:   par_err = par_xor;
      2'b10:   par_err = ~par_xor;
      2'b11:   par_err = ~par_bit_q;
      default: par_err = 1'b0;
    endcase
  end

  // Receive FSM: advances on baud ticks, aborts immediately when the receiver is disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      n_bits_q      <= '0;
      par_mode_q    <= 2'b00;
      stop2_q       <= 1'b0;
      stop_idx_q    <= 1'b0;
      s_pre_q       <= 1'b0;
      s_mid_q       <= 1'b0;
      data_q        <= '0;
      par_bit_q     <= 1'b0;
      noise_q       <= 1'b0;
      frame_q       <= 1'b0;
      first_stop_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      res_data_q    <= '0;
      res_par_err_q <= 1'b0;
      res_frame_q   <= 1'b0;
      res_break_q   <= 1'b0;
      res_noise_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!rx_en_i && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (baud_en_i) begin
        if (state_q != S_IDLE) begin
          cnt_q <= at_last ? '0 : cnt_q + SAMPLE_COUNT_W'(1);
          if (cnt_q == CNT_PRE) s_pre_q <= uart_rx_i;
          if (cnt_q == CNT_MID) s_mid_q <= uart_rx_i;
        end
        case (state_q)
          S_IDLE: begin
            if (rx_en_i && !uart_rx_i) begin
              // The falling-edge tick itself is sample 0 of the start bit
              state_q      <= S_START;
              cnt_q        <= SAMPLE_COUNT_W'(1);
              busy_q       <= 1'b1;
              n_bits_q     <= cfg_bits;
              par_mode_q   <= parity_mode_i;
              stop2_q      <= stop2_i;
              bit_idx_q    <= '0;
              stop_idx_q   <= 1'b0;
              data_q       <= '0;
              par_bit_q    <= 1'b0;
              noise_q      <= 1'b0;
              frame_q      <= 1'b0;
              first_stop_q <= 1'b0;
            end
          end
          S_START: begin
            if (at_vote) begin
              noise_q <= noise_q | split;
              if (vote) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else if (at_last) begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            if (at_vote) begin
              data_q[bit_idx_q] <= vote;
              noise_q           <= noise_q | split;
            end
            if (at_last) begin
              if (bit_idx_q == n_bits_q - DATA_LEN_W'(1)) begin
                state_q <= (par_mode_q != 2'b00) ? S_PARITY : S_STOP;
              end else begin
                bit_idx_q <= bit_idx_q + DATA_LEN_W'(1);
              end
            end
          end
          S_PARITY: begin
            if (at_vote) begin
              par_bit_q <= vote;
              noise_q   <= noise_q | split;
            end
            if (at_last) begin
              state_q <= S_STOP;
            end
          end
          S_STOP: begin
            if (at_vote) begin
              noise_q <= noise_q | split;
              frame_q <= frame_q | ~vote;
              if (!stop_idx_q) first_stop_q <= vote;
              if (final_stop) begin
                // Complete mid-bit so the next start edge is never missed
                done_q        <= 1'b1;
                res_data_q    <= data_q;
                res_par_err_q <= par_err & ~fin_break;
                res_frame_q   <= frame_q | ~vote;
                res_break_q   <= fin_break;
                res_noise_q   <= noise_q | split;
                busy_q        <= 1'b0;
                cnt_q         <= '0;
                state_q       <= vote ? S_IDLE : S_WAIT_IDLE;
              end
            end else if (at_last) begin
              stop_idx_q <= 1'b1;
            end
          end
          S_WAIT_IDLE: begin
            if (uart_rx_i) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Valid/ready holding register; a completed character with no room is dropped and flagged
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_valid_o      <= 1'b0;
      rx_data_o       <= '0;
      rx_parity_err_o <= 1'b0;
      rx_frame_err_o  <= 1'b0;
      rx_break_o      <= 1'b0;
      rx_noise_o      <= 1'b0;
      rx_overrun_o    <= 1'b0;
    end else begin
      rx_overrun_o <= 1'b0;
      if (done_q) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_valid_o      <= 1'b1;
          rx_data_o       <= res_data_q;
          rx_parity_err_o <= res_par_err_q;
          rx_frame_err_o  <= res_frame_q;
          rx_break_o      <= res_break_q;
          rx_noise_o      <= res_noise_q;
        end else begin
          rx_overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign rx_busy_o = busy_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - directed self-checking bench for uart_rx_engine
module tb_uart_rx_engine;

  localparam int OS   = 16;
  localparam int M    = OS / 2;
  localparam int BDIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_en;
  logic       rx_en;
  logic       rx_line;
  logic [3:0] data_bits;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       rx_ready;
  logic       rx_valid_o;
  logic [8:0] rx_data_o;
  logic       rx_parity_err_o;
  logic       rx_frame_err_o;
  logic       rx_break_o;
  logic       rx_noise_o;
  logic       rx_overrun_o;
  logic       rx_busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  int ncyc     = 0;
  int rise_cnt = 0;
  int rise_cyc = 0;
  int ovr_cnt  = 0;
  int start_cyc = 0;
  logic       vprev = 1'b0;
  logic [8:0] cap_data = '0;
  logic [8:0] cap_prev = '0;
  logic       cap_perr = 1'b0;
  logic       cap_ferr = 1'b0;
  logic       cap_brk  = 1'b0;
  logic       cap_noise = 1'b0;

  uart_rx_engine #(
    .MAX_DATA_W(9),
    .OVERSAMPLE(OS),
    .DATA_LEN_W(4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .baud_en_i      (baud_en),
    .rx_en_i        (rx_en),
    .uart_rx_i      (rx_line),
    .data_bits_i    (data_bits),
    .parity_mode_i  (parity_mode),
    .stop2_i        (stop2),
    .rx_ready_i     (rx_ready),
    .rx_valid_o     (rx_valid_o),
    .rx_data_o      (rx_data_o),
    .rx_parity_err_o(rx_parity_err_o),
    .rx_frame_err_o (rx_frame_err_o),
    .rx_break_o     (rx_break_o),
    .rx_noise_o     (rx_noise_o),
    .rx_overrun_o   (rx_overrun_o),
    .rx_busy_o      (rx_busy_o)
  );

  always #5 clk = ~clk;

  // one clock; outputs observed 1ns after the edge, character captured on valid rise
  task automatic clk1();
    @(posedge clk);
    #1;
    ncyc++;
    if (rx_valid_o && !vprev) begin
      rise_cnt++;
      rise_cyc  = ncyc;
      cap_prev  = cap_data;
      cap_data  = rx_data_o;
      cap_perr  = rx_parity_err_o;
      cap_ferr  = rx_frame_err_o;
      cap_brk   = rx_break_o;
      cap_noise = rx_noise_o;
    end
    vprev = rx_valid_o;
    if (rx_overrun_o) ovr_cnt++;
  endtask

  task automatic tick(input logic line);
    rx_line = line;
    baud_en = 1'b0;
    for (int i = 0; i < BDIV - 1; i++) clk1();
    baud_en = 1'b1;
    clk1();
    baud_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // noise_bit: data bit index inverted at sample M only (-1 none); short_stop ends right after the final vote
  task automatic send_frame(input logic [8:0] data, input int nbits, input logic [1:0] pmode,
                            input logic s2, input logic pbit, input int noise_bit, input logic short_stop);
    logic seq[13];
    int   nseq;
    int   nt;
    data_bits   = 4'(nbits);
    parity_mode = pmode;
    stop2       = s2;
    seq[0] = 1'b0;
    for (int i = 0; i < nbits; i++) seq[1+i] = data[i];
    nseq = 1 + nbits;
    if (pmode != 2'b00) begin
      seq[nseq] = pbit;
      nseq++;
    end
    seq[nseq] = 1'b1;
    nseq++;
    if (s2) begin
      seq[nseq] = 1'b1;
      nseq++;
    end
    for (int b = 0; b < nseq; b++) begin
      nt = (short_stop && b == nseq - 1) ? M + 2 : OS;
      for (int t = 0; t < nt; t++) begin
        tick(seq[b] ^ ((b == noise_bit + 1) && (noise_bit >= 0) && (t == M)));
        if (b == 0 && t == 0) begin
          start_cyc   = ncyc;
          data_bits   = 4'd2;
          parity_mode = ~pmode;
          stop2       = ~s2;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; baud_en = 1'b0; rx_en = 1'b1; rx_line = 1'b1; rx_ready = 1'b1;
    data_bits = 4'd8; parity_mode = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < 3; i++) clk1();
    n_checks++; if (rx_valid_o !== 1'b0) $display("FAIL rst_valid got=%b exp=0", rx_valid_o); else n_pass++;
    n_checks++; if (rx_data_o !== 9'h000) $display("FAIL rst_data got=%h exp=000", rx_data_o); else n_pass++;
    n_checks++; if (rx_parity_err_o !== 1'b0) $display("FAIL rst_perr got=%b exp=0", rx_parity_err_o); else n_pass++;
    n_checks++; if (rx_frame_err_o !== 1'b0) $display("FAIL rst_ferr got=%b exp=0", rx_frame_err_o); else n_pass++;
    n_checks++; if (rx_break_o !== 1'b0) $display("FAIL rst_break got=%b exp=0", rx_break_o); else n_pass++;
    n_checks++; if (rx_noise_o !== 1'b0) $display("FAIL rst_noise got=%b exp=0", rx_noise_o); else n_pass++;
    n_checks++; if (rx_overrun_o !== 1'b0) $display("FAIL rst_overrun got=%b exp=0", rx_overrun_o); else n_pass++;
    n_checks++; if (rx_busy_o !== 1'b0) $display("FAIL rst_busy got=%b exp=0", rx_busy_o); else n_pass++;
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_8n1();
    int r0;
    r0 = rise_cnt;
    send_frame(9'h0A5, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (rise_cnt !== r0 + 1) $display("FAIL 8n1_count got=%0d exp=%0d", rise_cnt - r0, 1); else n_pass++;
    n_checks++; if (rise_cyc !== start_cyc + BDIV * (9 * OS + M + 1) + 1)
      $display("FAIL 8n1_latency got=%0d exp=%0d", rise_cyc - start_cyc, BDIV * (9 * OS + M + 1) + 1); else n_pass++;
    n_checks++; if (cap_data !== 9'h0A5) $display("FAIL 8n1_data got=%h exp=0a5", cap_data); else n_pass++;
    n_checks++; if ({cap_perr, cap_ferr, cap_brk, cap_noise} !== 4'b0000)
      $display("FAIL 8n1_flags got=%b exp=0000", {cap_perr, cap_ferr, cap_brk, cap_noise}); else n_pass++;
    n_checks++; if (rx_valid_o !== 1'b0) $display("FAIL 8n1_valid_cleared got=%b exp=0", rx_valid_o); else n_pass++;
    n_checks++; if (rx_busy_o !== 1'b0) $display("FAIL 8n1_busy got=%b exp=0", rx_busy_o); else n_pass++;
  endtask

  task automatic test_9o2();
    send_frame(9'h1FF, 9, 2'b10, 1'b1, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (rise_cyc !== start_cyc + BDIV * (12 * OS + M + 1) + 1)
      $display("FAIL 9o2_latency got=%0d exp=%0d", rise_cyc - start_cyc, BDIV * (12 * OS + M + 1) + 1); else n_pass++;
    n_checks++; if (cap_data !== 9'h1FF) $display("FAIL 9o2_data got=%h exp=1ff", cap_data); else n_pass++;
    n_checks++; if ({cap_perr, cap_ferr} !== 2'b00) $display("FAIL 9o2_flags got=%b exp=00", {cap_perr, cap_ferr}); else n_pass++;
    send_frame(9'h1FF, 9, 2'b10, 1'b1, 1'b1, -1, 1'b0);
    idle(2);
    n_checks++; if (cap_data !== 9'h1FF) $display("FAIL 9o2b_data got=%h exp=1ff", cap_data); else n_pass++;
    n_checks++; if (cap_perr !== 1'b1) $display("FAIL 9o2b_perr got=%b exp=1", cap_perr); else n_pass++;
    n_checks++; if (cap_ferr !== 1'b0) $display("FAIL 9o2b_ferr got=%b exp=0", cap_ferr); else n_pass++;
  endtask

  task automatic test_glitch_noise();
    int r0;
    r0 = rise_cnt;
    data_bits = 4'd8; parity_mode = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b0);
    n_checks++; if (rx_busy_o !== 1'b1) $display("FAIL glitch_busy_hi got=%b exp=1", rx_busy_o); else n_pass++;
    for (int i = 0; i < 8; i++) tick(1'b1);
    n_checks++; if (rx_busy_o !== 1'b0) $display("FAIL glitch_busy_lo got=%b exp=0", rx_busy_o); else n_pass++;
    idle(40);
    n_checks++; if (rise_cnt !== r0) $display("FAIL glitch_novalid got=%0d exp=0", rise_cnt - r0); else n_pass++;
    send_frame(9'h055, 8, 2'b00, 1'b0, 1'b0, 3, 1'b0);
    idle(2);
    n_checks++; if (cap_data !== 9'h055) $display("FAIL noise_data got=%h exp=055", cap_data); else n_pass++;
    n_checks++; if (cap_noise !== 1'b1) $display("FAIL noise_flag got=%b exp=1", cap_noise); else n_pass++;
    n_checks++; if ({cap_perr, cap_ferr, cap_brk} !== 3'b000)
      $display("FAIL noise_other got=%b exp=000", {cap_perr, cap_ferr, cap_brk}); else n_pass++;
  endtask

  task automatic test_break();
    int r0;
    r0 = rise_cnt;
    data_bits = 4'd8; parity_mode = 2'b01; stop2 = 1'b0;
    for (int i = 0; i < 12 * OS; i++) tick(1'b0);
    n_checks++; if (rise_cnt !== r0 + 1) $display("FAIL brk_count got=%0d exp=1", rise_cnt - r0); else n_pass++;
    n_checks++; if (cap_brk !== 1'b1) $display("FAIL brk_flag got=%b exp=1", cap_brk); else n_pass++;
    n_checks++; if (cap_ferr !== 1'b1) $display("FAIL brk_ferr got=%b exp=1", cap_ferr); else n_pass++;
    n_checks++; if (cap_data !== 9'h000) $display("FAIL brk_data got=%h exp=000", cap_data); else n_pass++;
    n_checks++; if (cap_perr !== 1'b0) $display("FAIL brk_perr got=%b exp=0", cap_perr); else n_pass++;
    n_checks++; if (rx_busy_o !== 1'b0) $display("FAIL brk_wait_busy got=%b exp=0", rx_busy_o); else n_pass++;
    idle(2);
    send_frame(9'h03C, 8, 2'b01, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (rise_cnt !== r0 + 2) $display("FAIL brk_next_count got=%0d exp=2", rise_cnt - r0); else n_pass++;
    n_checks++; if (cap_data !== 9'h03C) $display("FAIL brk_next_data got=%h exp=03c", cap_data); else n_pass++;
    n_checks++; if ({cap_perr, cap_ferr, cap_brk} !== 3'b000)
      $display("FAIL brk_next_flags got=%b exp=000", {cap_perr, cap_ferr, cap_brk}); else n_pass++;
  endtask

  task automatic test_overrun();
    int o0;
    o0 = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(9'h011, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (ovr_cnt !== o0) $display("FAIL ovr_none got=%0d exp=0", ovr_cnt - o0); else n_pass++;
    send_frame(9'h022, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (ovr_cnt !== o0 + 1) $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt - o0); else n_pass++;
    n_checks++; if (rx_valid_o !== 1'b1) $display("FAIL ovr_valid got=%b exp=1", rx_valid_o); else n_pass++;
    n_checks++; if (rx_data_o !== 9'h011) $display("FAIL ovr_data got=%h exp=011", rx_data_o); else n_pass++;
    rx_ready = 1'b1;
    clk1();
    n_checks++; if (rx_valid_o !== 1'b0) $display("FAIL ovr_clear got=%b exp=0", rx_valid_o); else n_pass++;
    idle(2);
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rise_cnt;
    send_frame(9'h05A, 8, 2'b00, 1'b0, 1'b0, -1, 1'b1);
    send_frame(9'h0C3, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (rise_cnt !== r0 + 2) $display("FAIL b2b_count got=%0d exp=2", rise_cnt - r0); else n_pass++;
    n_checks++; if (cap_prev !== 9'h05A) $display("FAIL b2b_first got=%h exp=05a", cap_prev); else n_pass++;
    n_checks++; if (cap_data !== 9'h0C3) $display("FAIL b2b_second got=%h exp=0c3", cap_data); else n_pass++;
  endtask

  task automatic test_abort();
    int r0;
    int o0;
    r0 = rise_cnt;
    o0 = ovr_cnt;
    data_bits = 4'd8; parity_mode = 2'b00; stop2 = 1'b0;
    for (int i = 0; i < OS + 20; i++) tick(i < OS ? 1'b0 : 1'b1);
    n_checks++; if (rx_busy_o !== 1'b1) $display("FAIL abort_busy_hi got=%b exp=1", rx_busy_o); else n_pass++;
    rx_en = 1'b0;
    clk1();
    n_checks++; if (rx_busy_o !== 1'b0) $display("FAIL abort_busy_lo got=%b exp=0", rx_busy_o); else n_pass++;
    rx_en = 1'b1;
    idle(12 * OS);
    n_checks++; if ((rise_cnt !== r0) || (ovr_cnt !== o0))
      $display("FAIL abort_silent got=%0d/%0d exp=0/0", rise_cnt - r0, ovr_cnt - o0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int r0;
    rx_ready = 1'b0;
    send_frame(9'h05A, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (rx_valid_o !== 1'b1) $display("FAIL rmid_held got=%b exp=1", rx_valid_o); else n_pass++;
    for (int i = 0; i < 3 * OS; i++) tick(i < 2 * OS ? 1'b0 : 1'b1);
    n_checks++; if (rx_busy_o !== 1'b1) $display("FAIL rmid_busy_hi got=%b exp=1", rx_busy_o); else n_pass++;
    rst_n = 1'b0;
    #2;
    n_checks++; if (rx_valid_o !== 1'b0) $display("FAIL rmid_valid got=%b exp=0", rx_valid_o); else n_pass++;
    n_checks++; if (rx_data_o !== 9'h000) $display("FAIL rmid_data got=%h exp=000", rx_data_o); else n_pass++;
    n_checks++; if (rx_busy_o !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", rx_busy_o); else n_pass++;
    n_checks++; if ({rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_noise_o, rx_overrun_o} !== 5'b00000)
      $display("FAIL rmid_flags got=%b exp=00000",
               {rx_parity_err_o, rx_frame_err_o, rx_break_o, rx_noise_o, rx_overrun_o}); else n_pass++;
    clk1();
    clk1();
    rst_n = 1'b1;
    rx_ready = 1'b1;
    r0 = rise_cnt;
    idle(12 * OS);
    n_checks++; if ((rise_cnt !== r0) || (rx_valid_o !== 1'b0))
      $display("FAIL rmid_spurious got=%0d exp=0", rise_cnt - r0); else n_pass++;
    send_frame(9'h081, 8, 2'b00, 1'b0, 1'b0, -1, 1'b0);
    idle(2);
    n_checks++; if (cap_data !== 9'h081) $display("FAIL rmid_next_data got=%h exp=081", cap_data); else n_pass++;
    n_checks++; if ({cap_perr, cap_ferr, cap_brk, cap_noise} !== 4'b0000)
      $display("FAIL rmid_next_flags got=%b exp=0000", {cap_perr, cap_ferr, cap_brk, cap_noise}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_9o2();
    test_glitch_noise();
    test_break();
    test_overrun();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
